// File: rtl/sysio_bus_master_if.sv
// Peripheral register bus between the sysio bus master and its responders.
// Separate write and read address lanes, single-cycle we_o/rd_o strobes.
interface sysio_bus_master_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = 4;

    logic [ADDR_W-1:0] waddr_o;
    logic [DATA_W-1:0] data_o;
    logic [SEL_W-1:0]  sel_o;
    logic              we_o;
    logic [ADDR_W-1:0] raddr_o;
    logic              rd_o;
    logic [DATA_W-1:0] data_i;

    modport master (
        output waddr_o, data_o, sel_o, we_o, raddr_o, rd_o,
        input  data_i
    );

    modport slave (
        input  waddr_o, data_o, sel_o, we_o, raddr_o, rd_o,
        output data_i
    );
endinterface

// File: rtl/sysio_bus_master.sv
// Single-outstanding initiator for the sysio register bus: write, read and
// atomic read-modify-write bit-set / bit-clear, with a valid/ready response.
module sysio_bus_master #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [3:0]          cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                busy,
    sysio_bus_master_if.master  bus
);
    // RD_LATENCY is limited to 1..4, so the countdown never exceeds 3
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SEL_W = 4;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_RSP} state_e;
    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  sel_bus_q, sel_bus_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              rd_q, rd_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rmw_value;

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign bus.waddr_o = addr_q;
    assign bus.raddr_o = addr_q;
    assign bus.data_o  = data_q;
    assign bus.sel_o   = sel_bus_q;
    assign bus.we_o    = we_q;
    assign bus.rd_o    = rd_q;

    // Modified word for set/clear, computed on the full data width
    assign rmw_value = (op_q == OP_SET) ? (bus.data_i | wdata_q)
                                        : (bus.data_i & ~wdata_q);

    // Next-state and next-output decode; strobes default low so they pulse
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        data_d      = data_q;
        sel_bus_d   = sel_bus_q;
        rdata_d     = rdata_q;
        we_d        = 1'b0;
        rd_d        = 1'b0;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    sel_d   = cmd_sel;
                    if (op_e'(cmd_op) == OP_WRITE) begin
                        state_d   = S_WR;
                        we_d      = 1'b1;
                        data_d    = cmd_wdata;
                        sel_bus_d = cmd_sel;
                        rdata_d   = '0;
                    end else begin
                        state_d = S_RD;
                        rd_d    = 1'b1;
                    end
                end
            end
            S_RD: begin
                cnt_d   = CNT_W'(RD_LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = bus.data_i;
                    if (op_q == OP_READ) begin
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d   = S_WR;
                        we_d      = 1'b1;
                        data_d    = rmw_value;
                        sel_bus_d = sel_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR: begin
                state_d     = S_RSP;
                rsp_valid_d = 1'b1;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_WRITE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            data_q      <= '0;
            sel_bus_q   <= '0;
            rdata_q     <= '0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            sel_bus_q   <= sel_bus_d;
            rdata_q     <= rdata_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
endmodule

// File: tb/tb_sysio_bus_master.sv
// Bench for sysio_bus_master: two instances (RD_LATENCY 1 and 3), a byte-enabled
// register-file responder, a response scoreboard and a vector table.
module tb_sysio_bus_master;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        int          d;
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic [31:0] exp_mem;
        int          exp_lat;
        int          exp_rd_off;
        int          exp_we_off;
        int          exp_rd;
        int          exp_we;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [1:0]  cmd_op    [2];
    logic [7:0]  cmd_addr  [2];
    logic [31:0] cmd_wdata [2];
    logic [3:0]  cmd_sel   [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        busy      [2];
    logic [7:0]  waddr_o   [2];
    logic [7:0]  raddr_o   [2];
    logic [31:0] data_o    [2];
    logic [3:0]  sel_o     [2];
    logic        we_o      [2];
    logic        rd_o      [2];
    logic [31:0] data_i    [2];

    logic [31:0] mem     [2][256];
    logic [3:0]  rd_pipe [2];
    logic [31:0] rd_hold [2];
    logic        pl_we   [2];
    logic [7:0]  pl_addr [2];
    logic [31:0] pl_data [2];

    int   cyc;
    int   n_checks;
    int   n_fail;
    int   acc_cyc [2];
    int   we_cyc  [2];
    int   rd_cyc  [2];
    int   hs_cyc  [2];
    int   we_cnt  [2];
    int   rd_cnt  [2];
    int   rsp_cnt [2];
    bit   rsp_seen[2];
    logic [31:0] rsp_hold[2];
    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[11];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sysio_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

        sysio_bus_master #(
            .RD_LATENCY((g == 0) ? 1 : 3),
            .ADDR_W    (ADDR_W),
            .DATA_W    (DATA_W)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_op    (cmd_op[g]),
            .cmd_addr  (cmd_addr[g]),
            .cmd_wdata (cmd_wdata[g]),
            .cmd_sel   (cmd_sel[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .busy      (busy[g]),
            .bus       (bus)
        );

        assign waddr_o[g]  = bus.waddr_o;
        assign raddr_o[g]  = bus.raddr_o;
        assign data_o[g]   = bus.data_o;
        assign sel_o[g]    = bus.sel_o;
        assign we_o[g]     = bus.we_o;
        assign rd_o[g]     = bus.rd_o;
        assign bus.data_i  = data_i[g];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: register file with byte enables; read data only valid in the exact latency cycle
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            rd_pipe[d] <= {rd_pipe[d][2:0], rd_o[d]};
            if (rd_o[d]) rd_hold[d] <= mem[d][raddr_o[d]];
            if (pl_we[d]) mem[d][pl_addr[d]] <= pl_data[d];
            else if (we_o[d]) begin
                for (int b = 0; b < 4; b++)
                    if (sel_o[d][b]) mem[d][waddr_o[d]][8*b +: 8] <= data_o[d][8*b +: 8];
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++)
            data_i[d] = rd_pipe[d][(d == 0) ? 0 : 2] ? rd_hold[d] : 32'hDEAD_BEEF;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: strobe rules, response latency/stability and scoreboard pop
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                rsp_seen[d] = 1'b0;
            end else begin
                chk("strobe_overlap", 64'(we_o[d] & rd_o[d]), 64'd0);
                if (rsp_valid[d]) begin
                    chk("strobe_during_rsp", 64'(we_o[d] | rd_o[d]), 64'd0);
                    if (!rsp_seen[d]) begin
                        rsp_seen[d] = 1'b1;
                        rsp_hold[d] = rsp_rdata[d];
                        if (sbq.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_rsp: dut %0d rdata 0x%0h required no response", d, rsp_rdata[d]);
                        end else begin
                            chk("rsp_latency", 64'(cyc - acc_cyc[d]), 64'(sbq[0].lat));
                        end
                    end else begin
                        chk("rsp_stable", 64'(rsp_rdata[d]), 64'(rsp_hold[d]));
                    end
                    if (rsp_ready[d]) begin
                        if (sbq.size() > 0) begin
                            mon_e = sbq.pop_front();
                            chk("rsp_dut", 64'(d), 64'(mon_e.d));
                            chk("rsp_rdata", 64'(rsp_rdata[d]), 64'(mon_e.rdata));
                        end
                        rsp_seen[d] = 1'b0;
                        hs_cyc[d]   = cyc;
                        rsp_cnt[d]++;
                    end
                end
                if (we_o[d]) begin we_cnt[d]++; we_cyc[d] = cyc; end
                if (rd_o[d]) begin rd_cnt[d]++; rd_cyc[d] = cyc; end
                if (cmd_valid[d] && cmd_ready[d]) acc_cyc[d] = cyc;
            end
        end
    end

    task automatic preload(input int d, input logic [7:0] a, input logic [31:0] v);
        pl_addr[d] = a;
        pl_data[d] = v;
        pl_we[d]   = 1'b1;
        @(posedge clk);
        #1 pl_we[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [1:0] op, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        input logic [31:0] er, input int el, input bit push);
        int   n;
        exp_t e;
        if (push) begin
            e.d = d; e.rdata = er; e.lat = el;
            sbq.push_back(e);
        end
        cmd_op[d]    = op;
        cmd_addr[d]  = a;
        cmd_wdata[d] = wd;
        cmd_sel[d]   = s;
        cmd_valid[d] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready[d] && n < 50);
        chk("cmd_accept", 64'(cmd_ready[d]), 64'd1);
        @(posedge clk);
        #1 cmd_valid[d] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, input int target);
        int n;
        n = 0;
        while (rsp_cnt[d] < target && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_count", 64'(rsp_cnt[d]), 64'(target));
    endtask

    task automatic chk_idle_outputs(input string tag, input int d);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready[d]), 64'd1);
        chk({tag, "_busy"},      64'(busy[d]),      64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid[d]), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata[d]), 64'd0);
        chk({tag, "_we_o"},      64'(we_o[d]),      64'd0);
        chk({tag, "_rd_o"},      64'(rd_o[d]),      64'd0);
        chk({tag, "_waddr_o"},   64'(waddr_o[d]),   64'd0);
        chk({tag, "_raddr_o"},   64'(raddr_o[d]),   64'd0);
        chk({tag, "_data_o"},    64'(data_o[d]),    64'd0);
        chk({tag, "_sel_o"},     64'(sel_o[d]),     64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   we0, rd0, r0, n;
        vec_t v;

        //          d  op     addr   wdata          sel   init           rdata          mem            lat rdo weo rd we
        vecs[0]  = '{0, 2'b00, 8'h04, 32'hA5A5_0F0F, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_0F0F, 2, 0, 1, 0, 1};
        vecs[1]  = '{0, 2'b01, 8'h00, 32'h0000_0000, 4'h0, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 3, 1, 0, 1, 0};
        vecs[2]  = '{0, 2'b10, 8'h08, 32'h0000_000F, 4'hF, 32'h0000_00F0, 32'h0000_00F0, 32'h0000_00FF, 4, 1, 3, 1, 1};
        vecs[3]  = '{0, 2'b11, 8'h0C, 32'h0000_0030, 4'hF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00CF, 4, 1, 3, 1, 1};
        vecs[4]  = '{0, 2'b00, 8'h10, 32'hAABB_CCDD, 4'h5, 32'h1122_3344, 32'h0000_0000, 32'h11BB_33DD, 2, 0, 1, 0, 1};
        vecs[5]  = '{0, 2'b10, 8'h14, 32'h0001_0001, 4'h1, 32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF01, 4, 1, 3, 1, 1};
        vecs[6]  = '{0, 2'b11, 8'h18, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4, 1, 3, 1, 1};
        vecs[7]  = '{0, 2'b01, 8'hFF, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 3, 1, 0, 1, 0};
        vecs[8]  = '{1, 2'b11, 8'h20, 32'h0000_0030, 4'hF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00CF, 6, 1, 5, 1, 1};
        vecs[9]  = '{1, 2'b01, 8'h24, 32'h0000_0000, 4'h0, 32'h8765_4321, 32'h8765_4321, 32'h8765_4321, 5, 1, 0, 1, 0};
        vecs[10] = '{1, 2'b10, 8'h28, 32'h8000_0000, 4'h8, 32'h0000_0001, 32'h0000_0001, 32'h8000_0001, 6, 1, 5, 1, 1};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; cmd_op[d] = 2'b00; cmd_addr[d] = 8'h00;
            cmd_wdata[d] = 32'h0; cmd_sel[d] = 4'h0; rsp_ready[d] = 1'b1;
            pl_we[d] = 1'b0; pl_addr[d] = 8'h00; pl_data[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk_idle_outputs("reset", d);

        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            preload(v.d, v.addr, v.init);
            we0 = we_cnt[v.d]; rd0 = rd_cnt[v.d]; r0 = rsp_cnt[v.d];
            send(v.d, v.op, v.addr, v.wdata, v.sel, v.exp_rdata, v.exp_lat, 1'b1);
            wait_rsp(v.d, r0 + 1);
            chk("vec_mem", 64'(mem[v.d][v.addr]), 64'(v.exp_mem));
            chk("vec_we_count", 64'(we_cnt[v.d] - we0), 64'(v.exp_we));
            chk("vec_rd_count", 64'(rd_cnt[v.d] - rd0), 64'(v.exp_rd));
            if (v.exp_we != 0) chk("vec_we_offset", 64'(we_cyc[v.d] - acc_cyc[v.d]), 64'(v.exp_we_off));
            if (v.exp_rd != 0) chk("vec_rd_offset", 64'(rd_cyc[v.d] - acc_cyc[v.d]), 64'(v.exp_rd_off));
        end

        // Backpressure: response held 10 cycles with the next command already waiting
        preload(0, 8'h00, 32'h1234_5678);
        preload(0, 8'h30, 32'h0000_0000);
        rsp_ready[0] = 1'b0;
        r0 = rsp_cnt[0];
        send(0, 2'b01, 8'h00, 32'h0, 4'h0, 32'h1234_5678, 3, 1'b1);
        sbq.push_back('{0, 32'h0000_0000, 2});
        cmd_op[0] = 2'b00; cmd_addr[0] = 8'h30; cmd_wdata[0] = 32'h0BAD_F00D;
        cmd_sel[0] = 4'hF; cmd_valid[0] = 1'b1;
        n = 0;
        while (!rsp_valid[0] && n < 20) begin @(negedge clk); n++; end
        chk("bp_rsp_valid_seen", 64'(rsp_valid[0]), 64'd1);
        we0 = we_cnt[0]; rd0 = rd_cnt[0];
        repeat (10) begin
            @(negedge clk);
            chk("bp_cmd_ready", 64'(cmd_ready[0]), 64'd0);
            chk("bp_rsp_valid", 64'(rsp_valid[0]), 64'd1);
            chk("bp_rsp_rdata", 64'(rsp_rdata[0]), 64'h1234_5678);
        end
        chk("bp_no_we", 64'(we_cnt[0] - we0), 64'd0);
        chk("bp_no_rd", 64'(rd_cnt[0] - rd0), 64'd0);
        @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready[0] && n < 20);
        @(posedge clk);
        #1 cmd_valid[0] = 1'b0;
        chk("bp_accept_gap", 64'(acc_cyc[0] - hs_cyc[0]), 64'd1);
        wait_rsp(0, r0 + 2);
        chk("bp_write_mem", 64'(mem[0][8'h30]), 64'h0BAD_F00D);

        // Reset while a set operation is waiting for read data (RD_LATENCY 3)
        preload(1, 8'h40, 32'h0000_000F);
        we0 = we_cnt[1]; r0 = rsp_cnt[1];
        send(1, 2'b10, 8'h40, 32'h0000_00F0, 4'hF, 32'h0, 0, 1'b0);
        @(posedge clk);
        #1 chk("rst_busy_before", 64'(busy[1]), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("rst_wait", 1);
        repeat (10) @(posedge clk);
        #1;
        chk("rst_no_we", 64'(we_cnt[1] - we0), 64'd0);
        chk("rst_no_rsp", 64'(rsp_cnt[1] - r0), 64'd0);
        chk("rst_mem_untouched", 64'(mem[1][8'h40]), 64'h0000_000F);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
